// File: rtl/bist_pkg.sv
// Shared types and the MISR step function for the BIST signature analyzer.
// Optional cycle-count checking in the top is enabled by BIST_CYC_CHECK_EN.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPACT = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } bist_state_e;

   localparam int MISR_MAX_W = 64;
   localparam int CNT_W      = 16;

   // Operands are zero-extended to MISR_MAX_W; w selects the live width and its MSB feedback tap.
   function automatic logic [MISR_MAX_W-1:0] misr_next(
      input logic [MISR_MAX_W-1:0] sig,
      input logic [MISR_MAX_W-1:0] din,
      input logic [MISR_MAX_W-1:0] poly,
      input int                    w
   );
      logic [MISR_MAX_W-1:0] mask;
      logic [MISR_MAX_W-1:0] fb;
      if (w >= MISR_MAX_W) begin
         mask = {MISR_MAX_W{1'b1}};
      end else begin
         mask = (64'd1 << w) - 64'd1;
      end
      if (sig[w-1]) begin
         fb = poly;
      end else begin
         fb = {MISR_MAX_W{1'b0}};
      end
      return ((sig << 1) ^ fb ^ din) & mask;
   endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: loads SEED on reset/load, steps on enable, else holds.
module bist_misr
   import bist_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = 8'h1D,
   parameter logic [WIDTH-1:0] SEED  = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sig
);

   logic [WIDTH-1:0]      sig_r;
   logic [WIDTH-1:0]      sig_next_s;
   logic [MISR_MAX_W-1:0] step_s;

   // next MISR value from current contents and the response vector
   always_comb begin
      step_s     = misr_next(MISR_MAX_W'(sig_r), MISR_MAX_W'(din), MISR_MAX_W'(POLY), WIDTH);
      sig_next_s = step_s[WIDTH-1:0];
   end

   // signature register; load wins over enable
   always_ff @(posedge clk) begin
      if (reset) begin
         sig_r <= SEED;
      end else if (load) begin
         sig_r <= SEED;
      end else if (enable) begin
         sig_r <= sig_next_s;
      end else begin
         sig_r <= sig_r;
      end
   end

   assign sig = sig_r;

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST response compactor: MISR signature, golden compare, held pass/fail.
// Define BIST_CYC_CHECK_EN to also require exactly EXP_CYC compacted cycles for pass.
module bist_signature_analyzer
   import bist_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] POLY    = 8'h1D,
   parameter logic [WIDTH-1:0] SEED    = 8'h00,
   parameter logic [WIDTH-1:0] GOLDEN  = 8'h00,
   parameter int               EXP_CYC = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic             running,
   input  logic             finish,
   input  logic [WIDTH-1:0] resp_in,
   output logic [WIDTH-1:0] signature,
   output logic             sig_valid,
   output logic             pass,
   output logic             busy
);

   if (WIDTH < 2 || WIDTH > MISR_MAX_W || EXP_CYC < 0) begin : g_param_check
      $error("bist_signature_analyzer: unsupported WIDTH/EXP_CYC");
   end

   bist_state_e state_r, state_nx_s;
   logic        misr_en_s, cmp_s;
   logic        busy_nx_s, sig_valid_nx_s, pass_nx_s;
   logic        busy_r, sig_valid_r, pass_r;

   bist_misr #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_misr (
      .clk    (clk),
      .reset  (reset),
      .load   (init),
      .enable (misr_en_s),
      .din    (resp_in),
      .sig    (signature)
   );

`ifdef BIST_CYC_CHECK_EN
   localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_CYC);
   logic [CNT_W-1:0] cnt_r;

   // saturating count of compacted cycles
   always_ff @(posedge clk) begin
      if (reset || init) begin
         cnt_r <= 16'h0000;
      end else if (misr_en_s && (cnt_r != 16'hFFFF)) begin
         cnt_r <= cnt_r + 16'h0001;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cmp_s = (signature == GOLDEN) && (cnt_r == EXP_CNT);
`else
   assign cmp_s = (signature == GOLDEN);
`endif

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // next state; init overrides everything
   always_comb begin
      state_nx_s = state_r;
      if (init) begin
         state_nx_s = COMPACT;
      end else begin
         case (state_r)
            IDLE:    state_nx_s = IDLE;
            COMPACT: state_nx_s = finish ? COMPARE : COMPACT;
            COMPARE: state_nx_s = DONE;
            DONE:    state_nx_s = DONE;
            default: state_nx_s = IDLE;
         endcase
      end
   end

   // output decode, evaluated on the next state so the flops below present it with no input path
   always_comb begin
      misr_en_s      = (state_r == COMPACT) && running && !init;
      busy_nx_s      = (state_nx_s == COMPACT) || (state_nx_s == COMPARE);
      sig_valid_nx_s = (state_nx_s == DONE);
      if (init) begin
         pass_nx_s = 1'b0;
      end else if (state_r == COMPARE) begin
         pass_nx_s = cmp_s;
      end else begin
         pass_nx_s = pass_r;
      end
   end

   // registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r      <= 1'b0;
         sig_valid_r <= 1'b0;
         pass_r      <= 1'b0;
      end else begin
         busy_r      <= busy_nx_s;
         sig_valid_r <= sig_valid_nx_s;
         pass_r      <= pass_nx_s;
      end
   end

   assign busy      = busy_r;
   assign sig_valid = sig_valid_r;
   assign pass      = pass_r;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench: three analyzers (GOLDEN 4, 5, 8) share stimulus; expectations go through a queue.
module tb_bist_signature_analyzer;

   logic       clk = 1'b0;
   logic       reset, init, running, finish;
   logic [3:0] resp_in;
   logic [3:0] sig_a, sig_b, sig_c;
   logic       v_a, v_b, v_c, p_a, p_b, p_c, b_a, b_b, b_c;
   int         checks = 0;
   int         failures = 0;

   typedef struct {
      string      tag;
      int         inst;
      logic [3:0] sig;
      logic       v;
      logic       p;
      logic       b;
   } exp_t;
   exp_t sb[$];

`ifdef BIST_CYC_CHECK_EN
   localparam logic RUN4_PASS_C = 1'b0;
`else
   localparam logic RUN4_PASS_C = 1'b1;
`endif

   always #5 clk = ~clk;

   bist_signature_analyzer #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h4), .EXP_CYC(3)) dut_a (
      .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish), .resp_in(resp_in),
      .signature(sig_a), .sig_valid(v_a), .pass(p_a), .busy(b_a));
   bist_signature_analyzer #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h5), .EXP_CYC(3)) dut_b (
      .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish), .resp_in(resp_in),
      .signature(sig_b), .sig_valid(v_b), .pass(p_b), .busy(b_b));
   bist_signature_analyzer #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h8), .EXP_CYC(3)) dut_c (
      .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish), .resp_in(resp_in),
      .signature(sig_c), .sig_valid(v_c), .pass(p_c), .busy(b_c));

   task automatic tick_check();
      exp_t       e;
      logic [3:0] os;
      logic       ov, op, ob;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.inst)
            0:       begin os = sig_a; ov = v_a; op = p_a; ob = b_a; end
            1:       begin os = sig_b; ov = v_b; op = p_b; ob = b_b; end
            default: begin os = sig_c; ov = v_c; op = p_c; ob = b_c; end
         endcase
         checks += 4;
         assert (os === e.sig) else begin
            failures++;
            $error("FAIL %s/sig[%0d] observed=%h expected=%h", e.tag, e.inst, os, e.sig);
         end
         assert (ov === e.v) else begin
            failures++;
            $error("FAIL %s/sig_valid[%0d] observed=%b expected=%b", e.tag, e.inst, ov, e.v);
         end
         assert (op === e.p) else begin
            failures++;
            $error("FAIL %s/pass[%0d] observed=%b expected=%b", e.tag, e.inst, op, e.p);
         end
         assert (ob === e.b) else begin
            failures++;
            $error("FAIL %s/busy[%0d] observed=%b expected=%b", e.tag, e.inst, ob, e.b);
         end
      end
   endtask

   // drive one cycle of stimulus, queue the expected outputs, then clock and compare
   task automatic step(input string tag, input logic i, input logic r, input logic f,
                       input logic [3:0] d, input logic [3:0] s, input logic v,
                       input logic pa, input logic pb, input logic pc, input logic b);
      init    = i;
      running = r;
      finish  = f;
      resp_in = d;
      sb.push_back('{tag, 0, s, v, pa, b});
      sb.push_back('{tag, 1, s, v, pb, b});
      sb.push_back('{tag, 2, s, v, pc, b});
      tick_check();
   endtask

   initial begin
      reset = 1'b1; init = 1'b0; running = 1'b0; finish = 1'b0; resp_in = 4'h0;
      step("reset0", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("reset1", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step("fin_idle", 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("run_idle", 1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // run 1: 1,0,0 -> 4; only GOLDEN=4 passes
      step("init1", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r1_c1", 1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r1_c2", 1'b0, 1'b1, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r1_c3", 1'b0, 1'b1, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r1_fin", 1'b0, 1'b0, 1'b1, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r1_done", 1'b0, 1'b0, 1'b0, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("run_done", 1'b0, 1'b1, 1'b0, 4'h5, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("fin_done", 1'b0, 1'b0, 1'b1, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // run 2: reach 8, then feedback step with finish on the same cycle -> 3
      step("init2", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r2_c1", 1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r2_hold", 1'b0, 1'b0, 1'b0, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r2_c2", 1'b0, 1'b1, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r2_c3", 1'b0, 1'b1, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r2_c4", 1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r2_fbfin", 1'b0, 1'b1, 1'b1, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r2_done", 1'b0, 1'b0, 1'b0, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      // run 3: four cycles to 8; GOLDEN=8 passes unless the cycle count is checked
      step("init3", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r3_c1", 1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r3_c2", 1'b0, 1'b1, 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r3_c3", 1'b0, 1'b1, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r3_c4", 1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r3_fin", 1'b0, 1'b0, 1'b1, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r3_done", 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 1'b1, 1'b0, 1'b0, RUN4_PASS_C, 1'b0);
      // init priority over running+finish, then reset in the middle of a run
      step("init4", 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r4_c1", 1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("init_pri", 1'b1, 1'b1, 1'b1, 4'h7, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("no_cmp", 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("r4_c2", 1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      step("reset_mid", 1'b0, 1'b1, 1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step("post_reset", 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
